// File: rtl/cmplx_mult_seq_pkg.sv
// Shared definitions for the sequential complex multiplier: FSM states,
// multiplier step encoding and the result width rule.
package cmplx_mult_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [1:0] step_t;

   // One partial product per step, in issue order
   localparam step_t STEP_RR = 2'd0;  // ar*br, added to re
   localparam step_t STEP_II = 2'd1;  // ai*bi, subtracted from re
   localparam step_t STEP_RI = 2'd2;  // ar*bi, added to im
   localparam step_t STEP_IR = 2'd3;  // ai*br, added to im

   function automatic int res_width(input int dwidth);
      return 2 * dwidth + 1;
   endfunction

endpackage

// File: rtl/signed_mult.sv
// Combinational signed multiplier: full-precision product of two
// DWIDTH-bit two's-complement operands.
module signed_mult #(
   parameter int DWIDTH = 8
) (
   input  logic signed [DWIDTH-1:0]   a,
   input  logic signed [DWIDTH-1:0]   b,
   output logic signed [2*DWIDTH-1:0] p
);

   localparam int PW = 2 * DWIDTH;

   assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/cmplx_mult_seq.sv
// Sequential complex multiplier: one shared signed multiplier, four steps per
// result. Define CMPLX_MULT_SEQ_PIPE_EN to register the product before accumulation.
module cmplx_mult_seq
   import cmplx_mult_seq_pkg::*;
#(
   parameter int DWIDTH = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   op_val,
   output logic                                   op_rdy,
   input  logic signed [DWIDTH-1:0]               ar,
   input  logic signed [DWIDTH-1:0]               ai,
   input  logic signed [DWIDTH-1:0]               br,
   input  logic signed [DWIDTH-1:0]               bi,
   output logic                                   res_val,
   input  logic                                   res_rdy,
   output logic signed [res_width(DWIDTH)-1:0]    re,
   output logic signed [res_width(DWIDTH)-1:0]    im,
   output logic                                   busy
);

   localparam int PW = 2 * DWIDTH;
   localparam int RW = res_width(DWIDTH);

   state_t                   state_q;
   state_t                   state_d;
   step_t                    step_q;
   logic signed [DWIDTH-1:0] ar_q;
   logic signed [DWIDTH-1:0] ai_q;
   logic signed [DWIDTH-1:0] br_q;
   logic signed [DWIDTH-1:0] bi_q;
   logic signed [RW-1:0]     re_acc;
   logic signed [RW-1:0]     im_acc;

   logic signed [DWIDTH-1:0] mul_a;
   logic signed [DWIDTH-1:0] mul_b;
   logic signed [PW-1:0]     prod_p0;
   logic signed [PW-1:0]     acc_prod;
   step_t                    acc_step;
   logic                     acc_en;
   logic                     step_adv;
   logic                     mul_done;
   logic                     accept;

   function automatic logic signed [RW-1:0] sext_prod(input logic signed [PW-1:0] p);
      return {p[PW-1], p};
   endfunction

   assign accept = op_val && op_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_rdy  = 1'b0;
      res_val = 1'b0;
      busy    = 1'b1;
      case (state_q)
         IDLE: begin
            op_rdy = 1'b1;
            busy   = 1'b0;
            if (op_val) state_d = MUL;
         end
         MUL: begin
            if (mul_done) state_d = DONE;
         end
         DONE: begin
            res_val = 1'b1;
            if (res_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- stage p0: step-selected operands into the shared multiplier ----
   always_comb begin
      mul_a = ar_q;
      mul_b = br_q;
      case (step_q)
         STEP_RR: begin mul_a = ar_q; mul_b = br_q; end
         STEP_II: begin mul_a = ai_q; mul_b = bi_q; end
         STEP_RI: begin mul_a = ar_q; mul_b = bi_q; end
         STEP_IR: begin mul_a = ai_q; mul_b = br_q; end
         default: ;
      endcase
   end

   signed_mult #(.DWIDTH(DWIDTH)) u_mult (
      .a (mul_a),
      .b (mul_b),
      .p (prod_p0)
   );

`ifdef CMPLX_MULT_SEQ_PIPE_EN
   // ---- stage p1: registered product; one extra drain cycle ends MUL ----
   logic signed [PW-1:0] prod_p1;
   step_t                step_p1;
   logic                 vld_p1;
   logic                 drain_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_p1 <= '0;
         step_p1 <= STEP_RR;
         vld_p1  <= 1'b0;
         drain_q <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b0;
         drain_q <= 1'b0;
      end else if (state_q == MUL) begin
         if (drain_q) begin
            vld_p1 <= 1'b0;
         end else begin
            prod_p1 <= prod_p0;
            step_p1 <= step_q;
            vld_p1  <= 1'b1;
            drain_q <= (step_q == STEP_IR);
         end
      end
   end

   assign acc_en   = (state_q == MUL) && vld_p1;
   assign acc_step = step_p1;
   assign acc_prod = prod_p1;
   assign step_adv = (state_q == MUL) && !drain_q;
   assign mul_done = drain_q;
`else
   assign acc_en   = (state_q == MUL);
   assign acc_step = step_q;
   assign acc_prod = prod_p0;
   assign step_adv = (state_q == MUL);
   assign mul_done = (step_q == STEP_IR);
`endif

   // ---- accumulate: operand capture, step sequencing, re/im update ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar_q   <= '0;
         ai_q   <= '0;
         br_q   <= '0;
         bi_q   <= '0;
         re_acc <= '0;
         im_acc <= '0;
         step_q <= STEP_RR;
      end else if (accept) begin
         ar_q   <= ar;
         ai_q   <= ai;
         br_q   <= br;
         bi_q   <= bi;
         re_acc <= '0;
         im_acc <= '0;
         step_q <= STEP_RR;
      end else begin
         if (step_adv) step_q <= step_q + 2'd1;
         if (acc_en) begin
            case (acc_step)
               STEP_RR:          re_acc <= re_acc + sext_prod(acc_prod);
               STEP_II:          re_acc <= re_acc - sext_prod(acc_prod);
               STEP_RI, STEP_IR: im_acc <= im_acc + sext_prod(acc_prod);
               default: ;
            endcase
         end
      end
   end

   assign re = re_acc;
   assign im = im_acc;

endmodule
